// File: rtl/router_pkg.sv
// Shared types and constants for the router packet generator: header field
// widths, the illegal destination, the LFSR taps and the FSM state type.
package router_pkg;

  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;
  localparam logic [7:0]        LFSR_TAPS    = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PLD,
    PAR,
    GAP
  } state_t;

endpackage

// File: rtl/router_pkt_lfsr.sv
// Payload LFSR helper: seed load value (zero seed forced to 8'h01) and the
// single-step Galois shift, both purely combinational.
module router_pkt_lfsr
  import router_pkg::*;
(
  input  logic [7:0] seed,
  input  logic [7:0] cur,
  output logic [7:0] load_val,
  output logic [7:0] step_val
);

  // An all-zero state would lock the LFSR, so a zero seed starts it at 8'h01.
  assign load_val = (seed == 8'h00) ? 8'h01 : seed;
  assign step_val = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);

endmodule

// File: rtl/router_pkt_gen.sv
// Router packet source: header, generated payload, XOR parity, with busy
// back-pressure. Define ROUTER_PKT_GEN_LFSR_EN to build the LFSR payload mode.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int IFG_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic [7:0]        seed,
  input  logic              mode,
  input  logic              err_inject,
  input  logic              busy,
  output logic [7:0]        data_out,
  output logic              packet_valid,
  output logic              gen_busy,
  output logic              pkt_done,
  output logic              start_rej,
  output logic [15:0]       pkt_count
);

  localparam logic [3:0] GAP_LOAD = 4'(IFG_CYCLES - 1);

  state_t            state, state_nxt;
  logic [7:0]        data_nxt, parity_acc, parity_nxt, pld, pld_nxt;
  logic              valid_nxt, done_nxt, rej_nxt, lat_err, err_nxt;
  logic [15:0]       count_nxt;
  logic [LEN_W-1:0]  remaining, rem_nxt;
  logic [3:0]        gap_cnt, gap_nxt;
  logic [7:0]        first_byte, next_byte;

`ifdef ROUTER_PKT_GEN_LFSR_EN
  logic       lat_mode;
  logic [7:0] lfsr_load, lfsr_step;

  router_pkt_lfsr u_lfsr (
    .seed     (seed),
    .cur      (pld),
    .load_val (lfsr_load),
    .step_val (lfsr_step)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                    lat_mode <= 1'b0;
    else if (state == IDLE && start) lat_mode <= mode;
  end

  assign first_byte = mode ? lfsr_load : seed;
  assign next_byte  = lat_mode ? lfsr_step : pld + 8'd1;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign first_byte  = seed;
  assign next_byte   = pld + 8'd1;
`endif

  assign gen_busy = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      data_out     <= 8'h00;
      packet_valid <= 1'b0;
      pkt_done     <= 1'b0;
      start_rej    <= 1'b0;
      pkt_count    <= 16'h0000;
      parity_acc   <= 8'h00;
      remaining    <= '0;
      pld          <= 8'h00;
      lat_err      <= 1'b0;
      gap_cnt      <= 4'h0;
    end else begin
      state        <= state_nxt;
      data_out     <= data_nxt;
      packet_valid <= valid_nxt;
      pkt_done     <= done_nxt;
      start_rej    <= rej_nxt;
      pkt_count    <= count_nxt;
      parity_acc   <= parity_nxt;
      remaining    <= rem_nxt;
      pld          <= pld_nxt;
      lat_err      <= err_nxt;
      gap_cnt      <= gap_nxt;
    end
  end

  // pld always holds the next payload byte to present; it is advanced only on
  // a transfer so back-pressure can never skip or repeat a byte.
  always_comb begin
    state_nxt  = state;
    data_nxt   = data_out;
    valid_nxt  = packet_valid;
    done_nxt   = 1'b0;
    rej_nxt    = 1'b0;
    count_nxt  = pkt_count;
    parity_nxt = parity_acc;
    rem_nxt    = remaining;
    pld_nxt    = pld;
    err_nxt    = lat_err;
    gap_nxt    = gap_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          if (dest_addr == ILLEGAL_ADDR || payload_len == '0) begin
            rej_nxt = 1'b1;
          end else begin
            data_nxt   = {payload_len, dest_addr};
            valid_nxt  = 1'b1;
            parity_nxt = {payload_len, dest_addr};
            rem_nxt    = payload_len;
            pld_nxt    = first_byte;
            err_nxt    = err_inject;
            state_nxt  = HDR;
          end
        end
      end
      HDR, PLD: begin
        if (!busy) begin
          if (remaining != '0) begin
            data_nxt   = pld;
            parity_nxt = parity_acc ^ pld;
            rem_nxt    = remaining - 1'b1;
            pld_nxt    = next_byte;
            state_nxt  = PLD;
          end else begin
            data_nxt  = parity_acc ^ {7'b0, lat_err};
            valid_nxt = 1'b0;
            state_nxt = PAR;
          end
        end
      end
      PAR: begin
        if (!busy) begin
          data_nxt  = 8'h00;
          done_nxt  = 1'b1;
          count_nxt = pkt_count + 16'd1;
          if (IFG_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            gap_nxt   = GAP_LOAD;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 4'h0) state_nxt = IDLE;
        else                 gap_nxt   = gap_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Directed self-checking bench for router_pkt_gen (default IFG_CYCLES=2);
// the LFSR case runs only when ROUTER_PKT_GEN_LFSR_EN is defined.
module tb_router_pkt_gen;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [1:0]  dest_addr;
  logic [5:0]  payload_len;
  logic [7:0]  seed;
  logic        mode;
  logic        err_inject;
  logic        busy;
  logic [7:0]  data_out;
  logic        packet_valid;
  logic        gen_busy;
  logic        pkt_done;
  logic        start_rej;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;

  router_pkt_gen dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .dest_addr    (dest_addr),
    .payload_len  (payload_len),
    .seed         (seed),
    .mode         (mode),
    .err_inject   (err_inject),
    .busy         (busy),
    .data_out     (data_out),
    .packet_valid (packet_valid),
    .gen_busy     (gen_busy),
    .pkt_done     (pkt_done),
    .start_rej    (start_rej),
    .pkt_count    (pkt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Presents start for exactly one rising edge, then drops it.
  task automatic applyStimulus(input logic [5:0] len, input logic [1:0] addr,
                               input logic [7:0] sd, input logic md, input logic err);
    @(negedge clock);
    payload_len = len;
    dest_addr   = addr;
    seed        = sd;
    mode        = md;
    err_inject  = err;
    start       = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic expectByte(input string tag, input logic [7:0] b, input logic pv);
    @(negedge clock);
    checkOutput({tag, "_data"}, 16'(data_out), 16'(b));
    checkOutput({tag, "_pv"}, 16'(packet_valid), 16'(pv));
  endtask

  // Called right after the parity byte was observed; covers the done pulse and the 2-cycle gap.
  task automatic finishPacket(input string tag, input logic [15:0] exp_count);
    @(negedge clock);
    checkOutput({tag, "_done"}, 16'(pkt_done), 16'd1);
    checkOutput({tag, "_count"}, pkt_count, exp_count);
    checkOutput({tag, "_idle_data"}, 16'(data_out), 16'h0);
    checkOutput({tag, "_gap1_busy"}, 16'(gen_busy), 16'd1);
    @(negedge clock);
    checkOutput({tag, "_done_width"}, 16'(pkt_done), 16'd0);
    checkOutput({tag, "_gap2_busy"}, 16'(gen_busy), 16'd1);
    @(negedge clock);
    checkOutput({tag, "_gap_end"}, 16'(gen_busy), 16'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetn      = 1'b0;
    start       = 1'b0;
    dest_addr   = 2'd0;
    payload_len = 6'd0;
    seed        = 8'h00;
    mode        = 1'b0;
    err_inject  = 1'b0;
    busy        = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_data", 16'(data_out), 16'h0);
    checkOutput("rst_pv", 16'(packet_valid), 16'd0);
    checkOutput("rst_gen_busy", 16'(gen_busy), 16'd0);
    checkOutput("rst_done", 16'(pkt_done), 16'd0);
    checkOutput("rst_rej", 16'(start_rej), 16'd0);
    checkOutput("rst_count", pkt_count, 16'd0);
    resetn = 1'b1;

    $display("[TB] case 1: len=1 addr=0 seed=10");
    applyStimulus(6'd1, 2'd0, 8'h10, 1'b0, 1'b0);
    expectByte("c1_hdr", 8'h04, 1'b1);
    expectByte("c1_p0", 8'h10, 1'b1);
    expectByte("c1_par", 8'h14, 1'b0);
    finishPacket("c1", 16'd1);

    $display("[TB] case 2: len=3 addr=2 seed=FE, payload wraps");
    applyStimulus(6'd3, 2'd2, 8'hFE, 1'b0, 1'b0);
    expectByte("c2_hdr", 8'h0E, 1'b1);
    expectByte("c2_p0", 8'hFE, 1'b1);
    expectByte("c2_p1", 8'hFF, 1'b1);
    expectByte("c2_p2", 8'h00, 1'b1);
    expectByte("c2_par", 8'h0F, 1'b0);
    finishPacket("c2", 16'd2);

    $display("[TB] case 3: busy holds payload byte");
    applyStimulus(6'd1, 2'd0, 8'h10, 1'b0, 1'b0);
    expectByte("c3_hdr", 8'h04, 1'b1);
    expectByte("c3_p0a", 8'h10, 1'b1);
    busy = 1'b1;
    expectByte("c3_p0b", 8'h10, 1'b1);
    expectByte("c3_p0c", 8'h10, 1'b1);
    expectByte("c3_p0d", 8'h10, 1'b1);
    busy = 1'b0;
    expectByte("c3_par", 8'h14, 1'b0);
    finishPacket("c3", 16'd3);

    $display("[TB] case 4: illegal parameters rejected");
    applyStimulus(6'd2, 2'd3, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("c4a_rej", 16'(start_rej), 16'd1);
    checkOutput("c4a_pv", 16'(packet_valid), 16'd0);
    checkOutput("c4a_gen_busy", 16'(gen_busy), 16'd0);
    @(negedge clock);
    checkOutput("c4a_rej_width", 16'(start_rej), 16'd0);
    applyStimulus(6'd0, 2'd1, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("c4b_rej", 16'(start_rej), 16'd1);
    checkOutput("c4b_pv", 16'(packet_valid), 16'd0);
    @(negedge clock);
    checkOutput("c4b_rej_width", 16'(start_rej), 16'd0);
    checkOutput("c4_count", pkt_count, 16'd3);

    $display("[TB] case 5: parity error injection");
    applyStimulus(6'd1, 2'd0, 8'h10, 1'b0, 1'b1);
    expectByte("c5_hdr", 8'h04, 1'b1);
    expectByte("c5_p0", 8'h10, 1'b1);
    expectByte("c5_par", 8'h15, 1'b0);
    finishPacket("c5", 16'd4);

`ifdef ROUTER_PKT_GEN_LFSR_EN
    $display("[TB] case 6: LFSR with zero seed");
    applyStimulus(6'd2, 2'd1, 8'h00, 1'b1, 1'b0);
    expectByte("c6_hdr", 8'h09, 1'b1);
    expectByte("c6_p0", 8'h01, 1'b1);
    expectByte("c6_p1", 8'hB8, 1'b1);
    expectByte("c6_par", 8'hB0, 1'b0);
    finishPacket("c6", 16'd5);
`endif

    $display("[TB] case 7: reset during second payload byte");
    applyStimulus(6'd3, 2'd2, 8'hFE, 1'b0, 1'b0);
    expectByte("c7_hdr", 8'h0E, 1'b1);
    expectByte("c7_p0", 8'hFE, 1'b1);
    expectByte("c7_p1", 8'hFF, 1'b1);
    #1 resetn = 1'b0;
    #1;
    checkOutput("c7_rst_data", 16'(data_out), 16'h0);
    checkOutput("c7_rst_pv", 16'(packet_valid), 16'd0);
    checkOutput("c7_rst_gen_busy", 16'(gen_busy), 16'd0);
    checkOutput("c7_rst_count", pkt_count, 16'd0);
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(6'd1, 2'd0, 8'h10, 1'b0, 1'b0);
    expectByte("c7_hdr2", 8'h04, 1'b1);
    expectByte("c7_p0_2", 8'h10, 1'b1);
    expectByte("c7_par2", 8'h14, 1'b0);
    finishPacket("c7", 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_pkt_gen.md
# router_pkt_gen

Packet source that drives the router's input port with the same framing the router checks. Each packet is a header byte {payload_len[5:0], dest_addr[1:0]}, then 1–63 generated payload bytes, then a parity byte that is the XOR of the header and all payload bytes. It honours the router's `busy` back-pressure and sits in front of the router's `data_in`/`packet_valid` inputs, for traffic generation and loopback self-test.

## Interface
- `IFG_CYCLES`, default 2: idle gap cycles after a parity byte transfers, before the next `start` is accepted (legal 0–15).
- `clock` input 1: single clock; all state updates on its rising edge.
- `resetn` input 1: reset, asynchronous and active-low.
- `start` input 1: request one packet; sampled only while idle.
- `dest_addr` input 2: destination port; 2'b11 is illegal.
- `payload_len` input 6: payload byte count; 0 is illegal.
- `seed` input 8: first payload byte.
- `mode` input 1: 0 = incrementing payload, 1 = LFSR payload (see Configuration).
- `err_inject` input 1: sampled with `start`; corrupts that packet's parity byte.
- `busy` input 1: router back-pressure; high = current byte is not taken.
- `data_out` output 8: byte to the router's `data_in`.
- `packet_valid` output 1: high during header and payload; low during parity.
- `gen_busy` output 1: high from start acceptance through the end of the gap.
- `pkt_done` output 1: one-cycle pulse when the parity byte transfers.
- `start_rej` output 1: one-cycle pulse when `start` is ignored because of illegal parameters.
- `pkt_count` output 16: number of completed packets; wraps at 16'hFFFF→0.

## Operation
- FSM states: IDLE, HDR, PLD, PAR, GAP.
- **Transfer rule:** a byte transfers at any rising edge in HDR, PLD or PAR where `busy`=0. While `busy`=1, `data_out`, `packet_valid` and all internal state hold.
- **IDLE:**
  - `start`=1 with legal parameters: latch addr, len, mode, seed and err_inject. Load `data_out`={len,addr}, set `packet_valid`=1, parity_acc=header, remaining=len. Go to HDR.
  - `start`=1 with `dest_addr`=3 or `payload_len`=0: pulse `start_rej`, stay in IDLE.
  - `busy` has no effect on start acceptance.
- **HDR / PLD, on a transfer:**
  - If remaining>0: `data_out`=next payload byte, parity_acc^=that byte, remaining−1, state PLD.
  - If remaining=0: `data_out`=parity_acc (^8'h01 if err_inject was latched), `packet_valid`=0, state PAR.
- **Payload generation:**
  - The first payload byte is `seed`.
  - Incrementing mode: next = prev+1, modulo 256.
  - LFSR mode: next = prev[0] ? (prev>>1)^8'hB8 : prev>>1. A seed of 8'h00 is replaced by 8'h01, and that substituted value is transmitted.
- **PAR, on a transfer:** `data_out`=8'h00, pulse `pkt_done`, `pkt_count`+1. Go to GAP, or directly to IDLE if `IFG_CYCLES`=0.
- **GAP:** hold for `IFG_CYCLES` cycles, then go to IDLE. `start` is ignored during the gap.
- `gen_busy` = (state != IDLE).
- **Reset values:** `data_out`=0, `packet_valid`=0, `gen_busy`=0, `pkt_done`=0, `start_rej`=0, `pkt_count`=0, state=IDLE.
- **Reset mid-packet:** the packet is abandoned immediately, and `packet_valid` drops asynchronously.

## Timing
- `start` accepted at edge T: header appears on `data_out` with `packet_valid`=1 from T+1.
- With `busy` held low, a packet occupies len+2 consecutive cycles on `data_out`, followed by `IFG_CYCLES` idle cycles.
- Minimum start-to-start spacing is len+2+`IFG_CYCLES`+1 cycles.
- All outputs are registered. No combinational path from any input to any output.
- `pkt_done` and `start_rej` are exactly one cycle wide.
- `busy` can never cause a byte to be skipped or duplicated: each byte is presented until exactly one transfer edge.

## Configuration
- `ROUTER_PKT_GEN_LFSR_EN` defined: LFSR logic is present and `mode`=1 selects LFSR payload.
- Not defined: no LFSR logic is built, `mode` is ignored, and the payload is always incrementing.

## Structure
- Shared package `router_pkg`:
  - FSM state type.
  - Header field widths (LEN_W=6, ADDR_W=2).
  - Illegal address constant 2'b11.
  - LFSR tap constant 8'hB8.
- One sub-module, `router_pkt_lfsr`: holds seed load, the zero-seed substitution and the step function. Instantiated only under `ROUTER_PKT_GEN_LFSR_EN`.

## Test plan
- len=1, addr=0, seed=8'h10, inc mode, `busy`=0 → `data_out` sequence 04, 10 with `packet_valid`=1, then 14 with `packet_valid`=0; `pkt_done` pulse; `pkt_count`=1.
- len=3, addr=2, seed=8'hFE, inc mode → 0E, FE, FF, 00, then parity 0F (payload wraps through 00).
- Same as case 1 but `busy`=1 for 3 cycles while 8'h10 is presented → 8'h10 is held 4 cycles with `packet_valid`=1, then 14. Nothing is skipped or duplicated.
- `dest_addr`=3, or `payload_len`=0 → one `start_rej` pulse; `packet_valid` stays 0; `pkt_count` unchanged.
- Case 1 with `err_inject`=1 → parity byte 15. With LFSR enabled: seed=00, mode=1, len=2 → payload 01, B8.
- Assert `resetn` low during the second payload byte → all outputs 0 immediately. A new `start` after release produces a clean packet.
